// File: rtl/exe_wb_stage.sv
// EXE/WB pipeline register, RAW hazard resolution for ID and saturating perf counters.
// EXE_WB_FORWARD_EN selects operand forwarding; otherwise hazards raise a stall.
module exe_wb_hit_lane #(
  parameter int ASIZE = 5
) (
  input  logic             ex_commit,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             wb_wen,
  input  logic [ASIZE-1:0] wb_waddr,
  input  logic [ASIZE-1:0] id_raddr,
  output logic             hit_e,
  output logic             hit_w
);
  // ex_commit and wb_wen already exclude r0, so r0 can never match
  assign hit_e = ex_commit & (id_raddr == ex_waddr);
  assign hit_w = wb_wen    & (id_raddr == wb_waddr);
endmodule

module exe_wb_stage #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_wen,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic [DSIZE-1:0] ex_result,
  input  logic             id_valid,
  input  logic [ASIZE-1:0] id_raddr1,
  input  logic [ASIZE-1:0] id_raddr2,
  input  logic [DSIZE-1:0] id_rdata1,
  input  logic [DSIZE-1:0] id_rdata2,
  output logic             wb_wen,
  output logic [ASIZE-1:0] wb_waddr,
  output logic [DSIZE-1:0] wb_wdata,
  output logic [DSIZE-1:0] fwd_rdata1,
  output logic [DSIZE-1:0] fwd_rdata2,
  output logic             stall,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] stall_count
);
  localparam int NUM_SRC = 2;

  logic                            ex_commit;
  logic [NUM_SRC-1:0][ASIZE-1:0]   id_raddr;
  logic [NUM_SRC-1:0][DSIZE-1:0]   id_rdata;
  logic [NUM_SRC-1:0][DSIZE-1:0]   fwd_rdata;
  logic [NUM_SRC-1:0]              hit_e;
  logic [NUM_SRC-1:0]              hit_w;

  assign ex_commit = ex_valid & ex_wen & (ex_waddr != '0);
  assign id_raddr  = {id_raddr2, id_raddr1};
  assign id_rdata  = {id_rdata2, id_rdata1};

  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      exe_wb_hit_lane #(.ASIZE(ASIZE)) u_hit (
        .ex_commit (ex_commit),
        .ex_waddr  (ex_waddr),
        .wb_wen    (wb_wen),
        .wb_waddr  (wb_waddr),
        .id_raddr  (id_raddr[s]),
        .hit_e     (hit_e[s]),
        .hit_w     (hit_w[s])
      );
`ifdef EXE_WB_FORWARD_EN
      // EXE is the younger producer, so it beats WB
      assign fwd_rdata[s] = hit_e[s] ? ex_result :
                            hit_w[s] ? wb_wdata  : id_rdata[s];
`else
      assign fwd_rdata[s] = id_rdata[s];
`endif
    end
  endgenerate

  assign fwd_rdata1 = fwd_rdata[0];
  assign fwd_rdata2 = fwd_rdata[1];

`ifdef EXE_WB_FORWARD_EN
  assign stall = 1'b0;
`else
  assign stall = id_valid & (|hit_e | |hit_w);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_wen   <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else begin
      wb_wen   <= ex_commit;
      wb_waddr <= ex_waddr;
      wb_wdata <= ex_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_count <= '0;
      stall_count  <= '0;
    end else begin
      if (ex_valid && (retire_count != '1)) retire_count <= retire_count + CNT_W'(1);
      if (stall && (stall_count != '1))     stall_count  <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_exe_wb_stage.sv
// Bench for exe_wb_stage: directed vector tables plus random stimulus against a spec-level model.
module tb_exe_wb_stage;
`ifdef EXE_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_wen, id_valid;
  logic [4:0]  ex_waddr, id_raddr1, id_raddr2, wb_waddr;
  logic [31:0] ex_result, id_rdata1, id_rdata2, wb_wdata, fwd_rdata1, fwd_rdata2;
  logic        wb_wen, stall;
  logic [CNT_W-1:0] retire_count, stall_count;

  always #5 clk = ~clk;

  exe_wb_stage #(.DSIZE(32), .ASIZE(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_waddr(ex_waddr),
    .ex_result(ex_result), .id_valid(id_valid), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .fwd_rdata1(fwd_rdata1), .fwd_rdata2(fwd_rdata2), .stall(stall),
    .retire_count(retire_count), .stall_count(stall_count)
  );

  typedef struct packed {
    logic rst, exv, exw; logic [4:0] exa; logic [31:0] exr;
    logic idv; logic [4:0] ra1, ra2; logic [31:0] rd1, rd2;
  } in_t;
  typedef struct {
    in_t i; logic [31:0] f1, f2; logic st;
  } vec_t;

  int nvec = 0, nerr = 0;

  // model of what the WB register and counters should hold
  bit        m_wen;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  int        m_ret, m_stl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit commits();
    return ex_valid && ex_wen && ex_waddr != 0;
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] ra, input logic [31:0] rd);
    if (!FWD) return rd;
    if (commits() && ra == ex_waddr) return ex_result;
    if (m_wen && ra == m_waddr) return m_wdata;
    return rd;
  endfunction

  function automatic bit hazard(input logic [4:0] ra);
    return (commits() && ra == ex_waddr) || (m_wen && ra == m_waddr);
  endfunction

  function automatic bit exp_stall();
    if (FWD) return 1'b0;
    return id_valid && (hazard(id_raddr1) || hazard(id_raddr2));
  endfunction

  task automatic drive(input in_t v);
    @(negedge clk);
    rst = v.rst; ex_valid = v.exv; ex_wen = v.exw; ex_waddr = v.exa; ex_result = v.exr;
    id_valid = v.idv; id_raddr1 = v.ra1; id_raddr2 = v.ra2; id_rdata1 = v.rd1; id_rdata2 = v.rd2;
    #1;
    chk("wb_wen", 32'(wb_wen), 32'(m_wen));
    if (m_wen) begin
      chk("wb_waddr", 32'(wb_waddr), 32'(m_waddr));
      chk("wb_wdata", wb_wdata, m_wdata);
    end
    chk("fwd_rdata1", fwd_rdata1, exp_fwd(id_raddr1, id_rdata1));
    chk("fwd_rdata2", fwd_rdata2, exp_fwd(id_raddr2, id_rdata2));
    chk("stall", 32'(stall), 32'(exp_stall()));
    chk("retire_count", 32'(retire_count), 32'(m_ret));
    chk("stall_count", 32'(stall_count), 32'(m_stl));
  endtask

  task automatic edge_upd();
    bit st, cm;
    st = exp_stall();
    cm = commits();
    @(posedge clk);
    if (!rst) begin
      m_wen = 0; m_waddr = 0; m_wdata = 0; m_ret = 0; m_stl = 0;
    end else begin
      m_wen = cm; m_waddr = ex_waddr; m_wdata = ex_result;
      if (ex_valid) m_ret = (m_ret + 1 > CMAX) ? CMAX : m_ret + 1;
      if (st)       m_stl = (m_stl + 1 > CMAX) ? CMAX : m_stl + 1;
    end
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    drive(v.i);
    chk({tag, ".f1"}, fwd_rdata1, v.f1);
    chk({tag, ".f2"}, fwd_rdata2, v.f2);
    chk({tag, ".stall"}, 32'(stall), 32'(v.st));
    edge_upd();
  endtask

  function automatic in_t mk(input logic r, input logic exv, input logic exw, input logic [4:0] exa,
                             input logic [31:0] exr, input logic idv, input logic [4:0] ra1,
                             input logic [4:0] ra2, input logic [31:0] rd1, input logic [31:0] rd2);
    in_t t;
    t.rst = r; t.exv = exv; t.exw = exw; t.exa = exa; t.exr = exr;
    t.idv = idv; t.ra1 = ra1; t.ra2 = ra2; t.rd1 = rd1; t.rd2 = rd2;
    return t;
  endfunction

  vec_t tbl[8];
  vec_t seq[6];

  initial begin
    in_t r;
    // directed table: WB path, r0, priority, WB forward after a bubble, id_valid=0
    tbl[0] = '{mk(1,1,1,3,32'hA5,0,1,2,32'h10,32'h20), 32'h10, 32'h20, 0};
    tbl[1] = '{mk(1,1,1,0,32'hFF,1,3,4,32'h30,32'h40), FWD ? 32'hA5 : 32'h30, 32'h40, !FWD};
    tbl[2] = '{mk(1,1,1,0,32'hFFFF_FFFF,1,0,0,0,0), 0, 0, 0};
    tbl[3] = '{mk(1,1,1,5,32'h11,0,9,9,32'h99,32'h99), 32'h99, 32'h99, 0};
    tbl[4] = '{mk(1,1,1,5,32'h22,1,5,5,32'h99,32'h99), FWD ? 32'h22 : 32'h99, FWD ? 32'h22 : 32'h99, !FWD};
    tbl[5] = '{mk(1,0,1,5,32'h33,1,5,5,32'h99,32'h99), FWD ? 32'h22 : 32'h99, FWD ? 32'h22 : 32'h99, !FWD};
    tbl[6] = '{mk(1,0,0,5,32'h44,1,5,5,32'h99,32'h99), 32'h99, 32'h99, 0};
    tbl[7] = '{mk(1,1,1,6,32'h66,0,6,1,32'h1,32'h2), FWD ? 32'h66 : 32'h1, 32'h2, 0};
    // distance-1 hazard on r7 then distance-2 hazard on r8, upstream inserting bubbles
    seq[0] = '{mk(1,1,1,7,32'h77,1,7,2,32'h1,32'h2), FWD ? 32'h77 : 32'h1, 32'h2, !FWD};
    seq[1] = '{mk(1,0,0,0,0,1,7,2,32'h1,32'h2), FWD ? 32'h77 : 32'h1, 32'h2, !FWD};
    seq[2] = '{mk(1,0,0,0,0,1,7,2,32'h1,32'h2), 32'h1, 32'h2, 0};
    seq[3] = '{mk(1,1,1,8,32'h88,1,1,2,32'h1,32'h2), 32'h1, 32'h2, 0};
    seq[4] = '{mk(1,1,0,8,0,1,1,8,32'h1,32'h2), 32'h1, FWD ? 32'h88 : 32'h2, !FWD};
    seq[5] = '{mk(1,0,0,0,0,1,1,8,32'h1,32'h2), 32'h1, 32'h2, 0};

    rst = 0; ex_valid = 1; ex_wen = 1; ex_waddr = 3; ex_result = 32'h5;
    id_valid = 0; id_raddr1 = 0; id_raddr2 = 0; id_rdata1 = 0; id_rdata2 = 0;
    @(posedge clk); #1;
    m_wen = 0; m_waddr = 0; m_wdata = 0; m_ret = 0; m_stl = 0;

    // reset held with a valid instruction in EXE
    r = mk(0,1,1,3,32'h5,0,0,0,0,0);
    drive(r); edge_upd();
    drive(r); edge_upd();
    chk("rst.wb_wen", 32'(wb_wen), 0);
    chk("rst.retire", 32'(retire_count), 0);
    drive(mk(1,1,0,0,0,0,0,0,0,0)); edge_upd();
    chk("rst.release_retire", 32'(retire_count), 1);

    foreach (tbl[k]) begin
      run_vec(tbl[k], $sformatf("tbl%0d", k));
      if (k == 0) begin
        chk("wb.wen", 32'(wb_wen), 1);
        chk("wb.waddr", 32'(wb_waddr), 3);
        chk("wb.wdata", wb_wdata, 32'hA5);
      end
      if (k == 2) chk("r0.wb_wen", 32'(wb_wen), 0);
    end

    drive(mk(0,0,0,0,0,0,0,0,0,0)); edge_upd();
    foreach (seq[k]) begin
      run_vec(seq[k], $sformatf("seq%0d", k));
      if (k == 2) chk("stall_cnt.d1", 32'(stall_count), FWD ? 0 : 2);
      if (k == 5) chk("stall_cnt.d2", 32'(stall_count), FWD ? 0 : 3);
    end

    // saturation: 20 valid instructions into a 4-bit counter
    drive(mk(0,0,0,0,0,0,0,0,0,0)); edge_upd();
    for (int n = 0; n < 20; n++) begin
      drive(mk(1,1,0,0,0,0,0,0,0,0)); edge_upd();
    end
    chk("sat.retire", 32'(retire_count), CMAX);

    // random traffic, small address space to provoke hazards and r0 cases
    for (int n = 0; n < 400; n++) begin
      r = mk($urandom_range(19,0) != 0, 1'($urandom), 1'($urandom), 5'($urandom_range(3,0)),
             $urandom, 1'($urandom), 5'($urandom_range(3,0)), 5'($urandom_range(3,0)),
             $urandom, $urandom);
      drive(r); edge_upd();
    end
    drive(mk(1,0,0,0,0,0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
